// File: rtl/prio_enc_pkg.sv
// Shared definitions for the latched priority encoder: default request
// count, encoded index width calculation and the grant FSM state type.
package prio_enc_pkg;

   localparam int DEF_N = 8;

   // Width of an index able to address n request lines (n >= 2).
   function automatic int calc_w(input int n);
      return $clog2(n);
   endfunction

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority search. Index 'top' has the highest priority and
// priority falls with decreasing index, wrapping from 0 back to N-1.
module prio_enc_core
   import prio_enc_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = calc_w(N)
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] top,
   output logic [W-1:0] index,
   output logic         any
);

   int          t;
   logic [W-1:0] ti;

   // Walk from lowest to highest priority so the last hit wins.
   always_comb begin
      index = '0;
      any   = 1'b0;
      t     = 0;
      ti    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         t = int'(top) - i;
         if (t < 0) t = t + N;
         ti = W'(t);
         if (vec[ti]) begin
            index = ti;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_latch_enc.sv
// Latched priority encoder: sticky pending register, two-state grant FSM
// (IDLE/BUSY) and a registered code/valid pair driving a tristate stage.
// Handshake: valid (and drv_en) rises with a new code and both stay stable
// until ack is sampled high in BUSY; that edge clears the granted pend bit
// (unless the same request is re-asserted on that edge) and drops valid.
// ack seen in IDLE has no effect.
// Define PRIO_LATCH_ENC_ROTATE_EN for rotating priority: after index k is
// acknowledged, k-1 (mod N) becomes the highest priority.
module prio_latch_enc
   import prio_enc_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = calc_w(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic [W-1:0] code,
   output logic         valid,
   output logic         drv_en,
   output logic [N-1:0] pend
);

   state_t       state_q, state_d;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] code_q, code_d;
   logic         valid_q, valid_d;
   logic [W-1:0] top;
   logic [W-1:0] grant_idx;
   logic         grant_any;
   logic [N-1:0] clr_mask;

`ifdef PRIO_LATCH_ENC_ROTATE_EN
   logic [W-1:0] ptr_q, ptr_d;
   assign top = ptr_q;
`else
   assign top = W'(N - 1);
`endif

   prio_enc_core #(.N(N), .W(W)) u_core (
      .vec   (pend_q),
      .top   (top),
      .index (grant_idx),
      .any   (grant_any)
   );

   assign clr_mask = {{(N-1){1'b0}}, 1'b1} << code_q;

   // Next-state logic: capture requests, grant from IDLE, release on ack.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      valid_d = valid_q;
      pend_d  = pend_q | req;
`ifdef PRIO_LATCH_ENC_ROTATE_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (grant_any) begin
               code_d  = grant_idx;
               valid_d = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (ack) begin
               // New request on the same edge re-sets the bit (set wins).
               pend_d  = (pend_q & ~clr_mask) | req;
               valid_d = 1'b0;
               state_d = IDLE;
`ifdef PRIO_LATCH_ENC_ROTATE_EN
               ptr_d   = (code_q == '0) ? W'(N - 1) : (code_q - W'(1));
`endif
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset; reset also blocks capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
`ifdef PRIO_LATCH_ENC_ROTATE_EN
         ptr_q   <= W'(N - 1);
`endif
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         valid_q <= valid_d;
`ifdef PRIO_LATCH_ENC_ROTATE_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign code   = code_q;
   assign valid  = valid_q;
   assign drv_en = valid_q;
   assign pend   = pend_q;

endmodule

// File: doc/prio_latch_enc.md
PRIO_LATCH_ENC -- requirements
Module: prio_latch_enc

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of request lines; legal range 2..16.
REQ-002 SHALL have parameter W, default $clog2(N), meaning width of the encoded index.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N  meaning request lines; any pulse of at least one cycle is captured.
REQ-006 SHALL have port ack  input  1  meaning the downstream tristate stage has consumed the current code.
REQ-007 SHALL have port code  output  W  meaning the registered index of the granted request.
REQ-008 SHALL have port valid  output  1  meaning code holds a granted, unacknowledged index.
REQ-009 SHALL have port drv_en  output  1  meaning the bus-drive enable fed to the downstream tristate stage's state input; identical to valid.
REQ-010 SHALL have port pend  output  N  meaning the current pending-request register.

Function
REQ-011 SHALL OR req into pend on every clock edge, so each pend bit is sticky until granted and acknowledged.
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 IDLE: if pend is nonzero, SHALL register the highest-priority set index into code, set valid, and go to BUSY; otherwise SHALL stay in IDLE with valid=0.
REQ-014 Fixed priority: index N-1 highest, index 0 lowest.
REQ-015 BUSY: SHALL hold code and valid stable until ack=1 is sampled.
REQ-016 BUSY with ack=1: SHALL clear pend[code], deassert valid on that edge, and return to IDLE.
REQ-017 Simultaneous ack and req[code] on the same edge: set wins, so pend[code] stays 1 and is re-granted later.
REQ-018 ack sampled in IDLE SHALL be ignored.
REQ-019 Latency: req asserted before edge t sets pend at t; valid rises at edge t+1. Minimum grant-to-grant spacing is 2 cycles (BUSY->IDLE->BUSY).
REQ-020 Requests arriving while BUSY SHALL only update pend and SHALL NOT alter code.
REQ-021 code SHALL hold its last value while valid=0.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, pend=0, code=0, valid=0, drv_en=0, and the rotate pointer to N-1, independent of clk.
REQ-023 Reset asserted mid-grant SHALL discard all pending and granted requests.
REQ-024 While rst=1, req SHALL NOT be captured.

Configuration
REQ-025 Macro PRIO_LATCH_ENC_ROTATE_EN defined: priority SHALL rotate. After index k is acknowledged, index k-1 (mod N) becomes highest priority and k becomes lowest.
REQ-026 Macro PRIO_LATCH_ENC_ROTATE_EN undefined: priority SHALL be fixed per REQ-014, and no pointer register SHALL exist.

Structure
REQ-027 A shared package prio_enc_pkg SHALL hold the default N, the W calculation, and the FSM state typedef (IDLE, BUSY).
REQ-028 The priority search SHALL be a combinational sub-module named prio_enc_core, with inputs vector and top-priority index and outputs index and any.

Verification
REQ-029 req=8'b0000_0100 for 1 cycle -> valid=1 with code=2 one cycle after capture; ack -> valid=0 and pend=0.
REQ-030 req=8'b1000_0001 together (fixed mode) -> code=7 first; after ack, code=0; after second ack, pend=0.
REQ-031 BUSY with code=3, ack=1 and req[3]=1 on the same edge -> pend[3] remains 1, and code=3 is re-granted two cycles later.
REQ-032 rst pulsed between edges while valid=1, code=5, pend=8'h21 -> outputs immediately 0 with no clock edge required.
REQ-033 ROTATE_EN build, req=8'hFF held one cycle, ack every grant -> code sequence 7,6,5,4,3,2,1,0; repeat with req=8'h81 after granting 7 -> 0 granted before 7.
REQ-034 ack asserted while IDLE with pend=0 -> no state change and valid stays 0.
